// File: rtl/mtm_trigger_seq.sv
// Master-trigger sequencer: synchronizes NIM decisions, sequences TRIG1/TRIG2/CLEAR,
// and maintains the event (ENC) and spill (SNC) tag counters for the RM receivers.
module mtm_trigger_seq #(
    parameter int          PW         = 4,
    parameter int          SETUP      = 3,
    parameter int          L2_TIMEOUT = 64,
    parameter int          DEAD_MIN   = 16,
    parameter logic [13:0] ENC_INIT   = 14'h0000
) (
    input  logic        SYSCLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        L1_IN,
    input  logic        L2_IN,
    input  logic        FCLR_IN,
    input  logic        SPILL_IN,
    input  logic        BUSY_IN,
    output logic        TRIG1,
    output logic        TRIG2,
    output logic        CLEAR,
    output logic [13:0] ENC,
    output logic [9:0]  SNC,
    output logic        BUSY_OUT
);

    localparam logic [3:0] PW_LD4   = 4'(PW - 1);
    localparam logic [7:0] PW_LD8   = 8'(PW - 1);
    localparam logic [7:0] SETUP_LD = 8'(SETUP - 1);
    localparam logic [7:0] TO_LD    = 8'(L2_TIMEOUT - 1);
    localparam logic [7:0] DEAD_LD  = 8'(DEAD_MIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_L2,
        S_SETUP,
        S_T2,
        S_CLR,
        S_DEAD
    } state_t;

    state_t      state_q;
    logic [7:0]  seq_cnt_q;
    logic [3:0]  t1_cnt_q;
    logic        trig1_q, trig2_q, clear_q, busy_out_q, pend_q;
    logic [13:0] enc_q;
    logic [9:0]  snc_q;

    // Bit order: 0=L1, 1=L2, 2=FCLR, 3=SPILL, 4=BUSY (level only)
    logic [4:0]  in_vec;
    logic [4:0]  s1_q, s2_q, s3_q;
    logic [3:0]  edge_q;

    logic l1_edge, l2_edge, fclr_edge, spill_edge, busy_s;
    logic l1_accept, dead_done, spill_hold, busy_out_d;

    assign in_vec = {BUSY_IN, SPILL_IN, FCLR_IN, L2_IN, L1_IN};

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            edge_q <= '0;
        end else begin
            s1_q   <= in_vec;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= s2_q[3:0] & ~s3_q[3:0];
        end
    end

    assign l1_edge    = edge_q[0];
    assign l2_edge    = edge_q[1];
    assign fclr_edge  = edge_q[2];
    assign spill_edge = edge_q[3];
    // BUSY is taken from the same stage depth as the edges so both act with equal latency
    assign busy_s     = s3_q[4];

    assign l1_accept  = (state_q == S_IDLE) && l1_edge && ENABLE && !busy_s;
    assign dead_done  = (state_q == S_DEAD) && (seq_cnt_q == 8'd0) && !busy_s;
    assign spill_hold = (state_q == S_SETUP) || (state_q == S_T2);

    always_comb begin
        busy_out_d = 1'b1;
        if (state_q == S_IDLE) begin
            busy_out_d = l1_accept;
        end else begin
            busy_out_d = !dead_done;
        end
        busy_out_d = busy_out_d | busy_s | !ENABLE;
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            seq_cnt_q <= 8'd0;
            trig2_q   <= 1'b0;
            clear_q   <= 1'b0;
            enc_q     <= ENC_INIT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (l1_accept) begin
                        state_q   <= S_WAIT_L2;
                        seq_cnt_q <= TO_LD;
                    end
                end
                S_WAIT_L2: begin
                    // Fast clear outranks an L2 seen in the same cycle
                    if (fclr_edge || seq_cnt_q == 8'd0) begin
                        state_q   <= S_CLR;
                        clear_q   <= 1'b1;
                        seq_cnt_q <= PW_LD8;
                    end else if (l2_edge) begin
                        state_q   <= S_SETUP;
                        enc_q     <= enc_q + 14'd1;
                        seq_cnt_q <= SETUP_LD;
                    end else begin
                        seq_cnt_q <= seq_cnt_q - 8'd1;
                    end
                end
                S_SETUP: begin
                    if (seq_cnt_q == 8'd0) begin
                        state_q   <= S_T2;
                        trig2_q   <= 1'b1;
                        seq_cnt_q <= PW_LD8;
                    end else begin
                        seq_cnt_q <= seq_cnt_q - 8'd1;
                    end
                end
                S_T2: begin
                    if (seq_cnt_q == 8'd0) begin
                        state_q   <= S_DEAD;
                        trig2_q   <= 1'b0;
                        seq_cnt_q <= DEAD_LD;
                    end else begin
                        seq_cnt_q <= seq_cnt_q - 8'd1;
                    end
                end
                S_CLR: begin
                    if (seq_cnt_q == 8'd0) begin
                        state_q   <= S_DEAD;
                        clear_q   <= 1'b0;
                        seq_cnt_q <= DEAD_LD;
                    end else begin
                        seq_cnt_q <= seq_cnt_q - 8'd1;
                    end
                end
                S_DEAD: begin
                    if (seq_cnt_q != 8'd0) begin
                        seq_cnt_q <= seq_cnt_q - 8'd1;
                    end else if (!busy_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // TRIG1 runs on its own counter so it can overlap an early TRIG2/CLEAR
    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            trig1_q  <= 1'b0;
            t1_cnt_q <= 4'd0;
        end else if (l1_accept) begin
            trig1_q  <= 1'b1;
            t1_cnt_q <= PW_LD4;
        end else if (trig1_q) begin
            if (t1_cnt_q == 4'd0) begin
                trig1_q <= 1'b0;
            end else begin
                t1_cnt_q <= t1_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            snc_q  <= 10'd0;
            pend_q <= 1'b0;
        end else if (spill_hold) begin
            if (spill_edge) begin
                pend_q <= 1'b1;
            end
        end else if (spill_edge || pend_q) begin
            snc_q  <= snc_q + 10'd1;
            pend_q <= 1'b0;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            busy_out_q <= 1'b1;
        end else begin
            busy_out_q <= busy_out_d;
        end
    end

    assign TRIG1    = trig1_q;
    assign TRIG2    = trig2_q;
    assign CLEAR    = clear_q;
    assign ENC      = enc_q;
    assign SNC      = snc_q;
    assign BUSY_OUT = busy_out_q;

endmodule

// File: doc/mtm_trigger_seq.md
# mtm_trigger_seq

Master-trigger sequencer that generates the per-event trigger and tag stream consumed by the GPIO-RM receivers. It accepts L1/L2/fast-clear decisions and a spill-start marker from NIM, drives TRIG1, TRIG2 and CLEAR, and maintains the event-number (ENC) and spill-number (SNC) counters. It gates new triggers with the OR of the receivers' BUSY and drives BUSY_OUT back to the trigger logic. It sits directly upstream of the RM block, which latches ENC/SNC on the rising edge of TRIG2.

## Interface
Parameters:
- PW, 4: width in SYSCLK cycles of the TRIG1, TRIG2 and CLEAR pulses (1..15).
- SETUP, 3: cycles ENC/SNC are held stable before TRIG2 rises (1..15).
- L2_TIMEOUT, 64: cycles from L1 accept to automatic clear (2 µs at 32 MHz; 1..255).
- DEAD_MIN, 16: minimum cycles spent in DEAD (1..255).

Ports:
- SYSCLK  in  1  32 MHz system clock. One clock; reset is synchronous and active-low.
- RST_N  in  1  synchronous active-low reset.
- ENABLE  in  1  run enable, from a VME register; synchronous.
- L1_IN  in  1  L1 accept, NIM, asynchronous.
- L2_IN  in  1  L2 accept, NIM, asynchronous.
- FCLR_IN  in  1  L2 fast clear, NIM, asynchronous.
- SPILL_IN  in  1  spill-start marker, NIM, asynchronous.
- BUSY_IN  in  1  OR of RM busies, asynchronous.
- TRIG1  out  1  L1 trigger pulse.
- TRIG2  out  1  L2 trigger pulse (tag strobe).
- CLEAR  out  1  event clear pulse.
- ENC  out  14  event number counter.
- SNC  out  10  spill number counter.
- BUSY_OUT  out  1  trigger inhibit.

## Operation
- Each asynchronous input passes through a 2-flop synchronizer followed by an edge-detect register. Only rising edges act.
- FSM states: IDLE, WAIT_L2, SETUP, T2, CLR, DEAD.
- **IDLE:** an L1 edge with ENABLE=1 and synced BUSY_IN=0 fires a TRIG1 pulse of PW cycles and moves to WAIT_L2, loading the timeout counter with L2_TIMEOUT. An L1 edge under any other condition (or in any other state) is ignored.
- **WAIT_L2:**
  - FCLR edge or timeout expiry moves to CLR. FCLR has priority over L2 in the same cycle.
  - Otherwise an L2 edge does ENC <= ENC+1 and moves to SETUP.
  - These transitions may occur while TRIG1 is still high; TRIG1 completes its PW cycles regardless.
- **SETUP:** hold for SETUP cycles, then move to T2.
- **T2:** TRIG2 is high for PW cycles, then move to DEAD.
- **CLR:** CLEAR is high for PW cycles, then move to DEAD. ENC is unchanged.
- **DEAD:** stay for at least DEAD_MIN cycles and until synced BUSY_IN=0, then return to IDLE.
- **ENC:** 14-bit, wraps 3FFF -> 0000. It is never reset by a spill.
- **SNC:** 10-bit, wraps 3FF -> 000.
  - A SPILL edge increments SNC immediately in IDLE, WAIT_L2, CLR and DEAD.
  - In SETUP or T2 the increment is deferred via a pending flag and applied in the first cycle after leaving T2, so the tag is stable across TRIG2.
  - Multiple SPILL edges while pending collapse to one increment.
- **BUSY_OUT** = (state != IDLE) | synced BUSY_IN | !ENABLE, registered.
- **ENABLE falling mid-sequence:** the current sequence completes normally.

## Timing
- Reset (RST_N=0 at a clock edge):
  - FSM goes to IDLE.
  - ENC=0, SNC=0, TRIG1=TRIG2=CLEAR=0, BUSY_OUT=1, pending flag cleared, synchronizers cleared.
  - Reset mid-sequence aborts any pulse in the next cycle.
- Input latency: with an input first sampled high at edge k, the edge pulse appears at k+2 and outputs/state change at k+3.
- TRIG1 is high for cycles k+3 .. k+3+PW-1.
- After an L2 edge is sampled at edge j:
  - ENC shows the new value from j+3.
  - TRIG2 rises at j+3+SETUP and is high for PW cycles.
- With the FCLR/timeout decision taken at cycle c, CLEAR is high for cycles c .. c+PW-1.
- Timeout: with defaults, CLEAR rises exactly 64 cycles after TRIG1 rises if no L2/FCLR arrives.
- Minimum L1-to-L1 spacing: 3 + SETUP + PW + DEAD_MIN + 1 cycles after the L2 accept (BUSY_IN low).
- TRIG pulses never overlap each other except TRIG1 with TRIG2/CLEAR when L2/FCLR arrives within PW cycles of L1.

## Test plan
- Reset, ENABLE=1, L1 edge then L2 edge 20 cycles later -> TRIG1 4 cycles wide 3 cycles after L1; ENC 0->1; TRIG2 rises 3 cycles after ENC changes, 4 wide; BUSY_OUT drops 16 cycles after TRIG2 ends.
- L1 with no L2 -> CLEAR 4 cycles wide starting 64 cycles after TRIG1 rise; ENC stays 0.
- L2 and FCLR edges in the same cycle in WAIT_L2 -> CLEAR only, no TRIG2, ENC unchanged.
- BUSY_IN held high from 5 cycles before L1 -> no TRIG1; then BUSY_IN high through DEAD -> IDLE reached 3 cycles after BUSY_IN falls; second L1 accepted.
- SPILL edge landing in SETUP -> SNC unchanged through TRIG2, increments by 1 the cycle after T2 ends. Preload ENC=3FFF -> L2 accept wraps ENC to 0000.
- RST_N asserted mid-TRIG2 -> TRIG2 low, ENC=SNC=0, BUSY_OUT=1 in the next cycle.
